rx_bert_sequencer: RTL
======================

RX_BERT_SEQUENCER -- requirements
Module: rx_bert_sequencer

Interface
REQ-001 Parameters SHALL be: Ways, default 2, number of BERT ways; BERCountWidth, default 41, width of each count; SettleCycles, default 4, cycles between seed lock and counting; DrainCycles, default 3, cycles between count stop and result capture.
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request for one measurement.
- abort  in  1  cancels a measurement in progress.
- way_mask  in  Ways  ways that take part in the measurement.
- seed_timeout  in  16  maximum number of SEED cycles.
- dwell_sel  in  4  requested shutoff bit select.
- prbs_seed_good  in  Ways  seed status from the BERT.
- ber_shutoff  in  1  dwell reached, from the BERT.
- ber_count  in  Ways*BERCountWidth  per-way error counts.
- bit_count  in  BERCountWidth  total bit count.
- bert_reset  out  1  reset to the BERT.
- pgen_seed_mode  out  Ways  1 = self-seed from data, 0 = free-run.
- ber_count_enable  out  Ways  counting enable.
- ber_shutoff_sel  out  4  shutoff select driven to the BERT.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err_seed  out  1  sticky: seed lock timed out.
- err_cfg  out  1  sticky: start was issued with way_mask==0.
- result_ber  out  Ways*BERCountWidth  captured error counts.
- result_bits  out  BERCountWidth  captured bit count.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, CLEAR, SEED, LOCK, COUNT, DRAIN, CAPTURE, one state register, advancing on rising clk edges.
REQ-004 In IDLE, start=1 with way_mask!=0 SHALL load way_mask and dwell_sel into internal registers, clear err_seed and err_cfg, and enter CLEAR.
REQ-005 In IDLE, start=1 with way_mask==0 SHALL set err_cfg, pulse done for one cycle, and remain in IDLE.
REQ-006 start SHALL be ignored in every state other than IDLE.
REQ-007 CLEAR SHALL last exactly 2 cycles with bert_reset=1; bert_reset SHALL be 0 in all other states.
REQ-008 In SEED, pgen_seed_mode SHALL equal the latched mask; all other states SHALL drive pgen_seed_mode=0.
REQ-009 SEED exits to LOCK after (prbs_seed_good & mask)==mask holds on 2 consecutive cycles.
REQ-010 SEED SHALL count its cycles from 0; on reaching seed_timeout with no lock, set err_seed, pulse done, and return to IDLE with no capture.
REQ-011 seed_timeout=0 SHALL time out on the first SEED cycle unless lock is seen that same cycle.
REQ-012 LOCK SHALL last exactly SettleCycles cycles, then enter COUNT.
REQ-013 In COUNT, ber_count_enable SHALL equal the latched mask; it SHALL be 0 in all other states.
REQ-014 COUNT exits to DRAIN on the first cycle with ber_shutoff=1.
REQ-015 With a latched dwell_sel of 0, COUNT SHALL persist until abort.
REQ-016 ber_shutoff_sel SHALL always drive the latched dwell_sel, which resets to 0.
REQ-017 DRAIN SHALL last exactly DrainCycles cycles, then enter CAPTURE.
REQ-018 CAPTURE SHALL last 1 cycle: latch ber_count into result_ber and bit_count into result_bits, assert done, then return to IDLE.
REQ-019 result_ber and result_bits SHALL change only in CAPTURE or on reset.
REQ-020 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge with all enables 0, no done pulse, and results unchanged.
REQ-021 If abort and a state exit occur in the same cycle, abort SHALL win.
REQ-022 abort SHALL have no effect in IDLE.
REQ-023 All outputs SHALL be registered.
REQ-024 The seed and settle/drain counters SHALL saturate, never wrap.

Reset
REQ-025 reset=1 at a clk edge SHALL force IDLE from any state, including mid-COUNT.
REQ-026 reset SHALL zero all outputs and internal registers; bert_reset SHALL be 0 at reset exit.
REQ-027 reset has priority over start and abort.

Verification
REQ-028 Nominal run: Ways=2, mask=2'b11, seed good 5 cycles after SEED entry, ber_shutoff 100 cycles into COUNT, ber_count={41'd3,41'd7} -> done exactly once, result_ber={3,7}, err_seed=0.
REQ-029 Seed timeout: seed_timeout=10, prbs_seed_good held at 0 -> done and err_seed=1 at cycle 10 of SEED; result_* unchanged; ber_count_enable never asserted.
REQ-030 Partial mask: mask=2'b01, prbs_seed_good=2'b01 -> lock is reached and ber_count_enable=2'b01 throughout COUNT.
REQ-031 Abort in COUNT -> next cycle busy=0, ber_count_enable=0, done never pulses.
REQ-032 Config error and noise: start with mask=0 -> err_cfg=1 and a 1-cycle done; start while busy causes no state change.
REQ-033 Reset mid-SEED -> all outputs 0 on the next cycle; a subsequent start completes normally.

Source files
------------

// File: rtl/rx_bert_sequencer.sv
// Receive-side BERT measurement sequencer: clears the checker, waits for PRBS
// seed lock, settles, counts until shutoff, drains, then captures the counts.
module rx_bert_sequencer #(
  parameter int Ways          = 2,
  parameter int BERCountWidth = 41,
  parameter int SettleCycles  = 4,
  parameter int DrainCycles   = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [Ways-1:0]               way_mask,
  input  logic [15:0]                   seed_timeout,
  input  logic [3:0]                    dwell_sel,
  input  logic [Ways-1:0]               prbs_seed_good,
  input  logic                          ber_shutoff,
  input  logic [Ways*BERCountWidth-1:0] ber_count,
  input  logic [BERCountWidth-1:0]      bit_count,
  output logic                          bert_reset,
  output logic [Ways-1:0]               pgen_seed_mode,
  output logic [Ways-1:0]               ber_count_enable,
  output logic [3:0]                    ber_shutoff_sel,
  output logic                          busy,
  output logic                          done,
  output logic                          err_seed,
  output logic                          err_cfg,
  output logic [Ways*BERCountWidth-1:0] result_ber,
  output logic [BERCountWidth-1:0]      result_bits
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, SEED, LOCK, COUNT, DRAIN, CAPTURE
  } state_e;

  localparam int SettleLast = (SettleCycles > 1) ? SettleCycles - 1 : 0;
  localparam int DrainLast  = (DrainCycles > 1) ? DrainCycles - 1 : 0;

  state_e                        state_q, state_d;
  logic [15:0]                   cnt_q, cnt_d;
  logic                          good_q, good_d;
  logic [Ways-1:0]               mask_q;
  logic [3:0]                    dwell_q;
  logic                          bert_reset_q, busy_q, done_q, err_seed_q, err_cfg_q;
  logic [Ways-1:0]               pgen_q, en_q;
  logic [Ways*BERCountWidth-1:0] res_ber_q;
  logic [BERCountWidth-1:0]      res_bits_q;

  logic good_now, load, cfg_err, tmo, cap;

  assign good_now = (prbs_seed_good & mask_q) == mask_q;

  always_comb begin
    state_d = state_q;
    good_d  = 1'b0;
    load    = 1'b0;
    cfg_err = 1'b0;
    tmo     = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (|way_mask) begin
            state_d = CLEAR;
            load    = 1'b1;
          end else begin
            cfg_err = 1'b1;
          end
        end
      end
      CLEAR:   if (cnt_q >= 16'd1) state_d = SEED;
      SEED: begin
        // A good cycle at the timeout boundary earns one more cycle to confirm lock.
        good_d = good_now;
        if (good_now && good_q) begin
          state_d = LOCK;
        end else if (cnt_q >= seed_timeout && !good_now) begin
          state_d = IDLE;
          tmo     = 1'b1;
        end
      end
      LOCK:    if (cnt_q >= 16'(SettleLast)) state_d = COUNT;
      COUNT:   if (ber_shutoff && dwell_q != 4'd0) state_d = DRAIN;
      DRAIN:   if (cnt_q >= 16'(DrainLast)) state_d = CAPTURE;
      CAPTURE: begin
        state_d = IDLE;
        cap     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      good_d  = 1'b0;
      tmo     = 1'b0;
      cap     = 1'b0;
    end
  end

  // One shared per-state cycle counter; restarts on every transition, never wraps.
  always_comb begin
    cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    if (state_d != state_q) cnt_d = 16'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      good_q       <= 1'b0;
      mask_q       <= '0;
      dwell_q      <= '0;
      bert_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_seed_q   <= 1'b0;
      err_cfg_q    <= 1'b0;
      pgen_q       <= '0;
      en_q         <= '0;
      res_ber_q    <= '0;
      res_bits_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      good_q       <= good_d;
      bert_reset_q <= (state_d == CLEAR);
      busy_q       <= (state_d != IDLE);
      pgen_q       <= (state_d == SEED)  ? mask_q : '0;
      en_q         <= (state_d == COUNT) ? mask_q : '0;
      done_q       <= cfg_err | tmo | cap;
      if (load) begin
        mask_q     <= way_mask;
        dwell_q    <= dwell_sel;
        err_seed_q <= 1'b0;
        err_cfg_q  <= 1'b0;
      end
      if (cfg_err) err_cfg_q  <= 1'b1;
      if (tmo)     err_seed_q <= 1'b1;
      if (cap) begin
        res_ber_q  <= ber_count;
        res_bits_q <= bit_count;
      end
    end
  end

  assign bert_reset       = bert_reset_q;
  assign pgen_seed_mode   = pgen_q;
  assign ber_count_enable = en_q;
  assign ber_shutoff_sel  = dwell_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err_seed         = err_seed_q;
  assign err_cfg          = err_cfg_q;
  assign result_ber       = res_ber_q;
  assign result_bits      = res_bits_q;

endmodule
